// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters, with burst lock.
// Define MEM_ARB_WR_PRIO_EN to give pending writes priority over reads.
module mem_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH_DATA = 8,
    parameter int WIDTH_ADDR = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_wr,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*WIDTH_ADDR-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH_DATA-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [WIDTH_DATA-1:0]         rsp_rdata,
    output logic [WIDTH_ADDR-1:0]         mem_addr,
    output logic [WIDTH_DATA-1:0]         mem_din,
    output logic                          mem_wen,
    output logic                          mem_ren,
    input  logic [WIDTH_DATA-1:0]         mem_dout
);

    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   lock_id_q, lock_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_vld;
    logic             lock_hold;
    logic [NUM_REQ-1:0] lock_mask;
    logic [NUM_REQ-1:0] elig;
`ifdef MEM_ARB_WR_PRIO_EN
    logic [NUM_REQ-1:0] wr_elig;
`endif

    logic           tag_vld_q [RD_LATENCY];
    logic           tag_vld_d [RD_LATENCY];
    logic [IDW-1:0] tag_id_q  [RD_LATENCY];
    logic [IDW-1:0] tag_id_d  [RD_LATENCY];

    // Reset gates eligibility so every port output is quiet while rst_n is low.
    always_comb begin
        lock_mask            = '0;
        lock_mask[lock_id_q] = 1'b1;
        lock_hold = (state_q == LOCKED) && req_lock[lock_id_q];
        elig      = req_valid & {NUM_REQ{rst_n}};
        if (lock_hold) begin
            elig = elig & lock_mask;
        end
`ifdef MEM_ARB_WR_PRIO_EN
        wr_elig = elig & req_wr;
        if (|wr_elig) begin
            elig = wr_elig;
        end
`endif
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_vld && elig[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                gnt_vld = 1'b1;
                gnt_id  = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        mem_wen   = 1'b0;
        mem_ren   = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        if (gnt_vld) begin
            req_ready[gnt_id] = 1'b1;
            mem_wen  = req_wr[gnt_id];
            mem_ren  = ~req_wr[gnt_id];
            mem_addr = req_addr[gnt_id*WIDTH_ADDR +: WIDTH_ADDR];
            mem_din  = req_wdata[gnt_id*WIDTH_DATA +: WIDTH_DATA];
        end
    end

    // A released lock may be re-acquired by the winner of the same cycle.
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        rr_ptr_d  = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
        end
        unique case (state_q)
            IDLE: begin
                if (gnt_vld && req_lock[gnt_id]) begin
                    state_d   = LOCKED;
                    lock_id_d = gnt_id;
                end
            end
            LOCKED: begin
                if (!lock_hold) begin
                    state_d = IDLE;
                    if (gnt_vld && req_lock[gnt_id]) begin
                        state_d   = LOCKED;
                        lock_id_d = gnt_id;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tag_vld_d[0] = gnt_vld & ~req_wr[gnt_id];
        tag_id_d[0]  = gnt_id;
        for (int s = 1; s < RD_LATENCY; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        rsp_rdata = '0;
        if (tag_vld_q[RD_LATENCY-1]) begin
            rsp_valid[tag_id_q[RD_LATENCY-1]] = 1'b1;
            rsp_rdata = mem_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lock_id_q <= '0;
            rr_ptr_q  <= '0;
            for (int s = 0; s < RD_LATENCY; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_id_q[s]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            rr_ptr_q  <= rr_ptr_d;
            for (int s = 0; s < RD_LATENCY; s++) begin
                tag_vld_q[s] <= tag_vld_d[s];
                tag_id_q[s]  <= tag_id_d[s];
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (read latency 1 and 2) share one directed stimulus stream.
// Each drives its own RAM model; monitors compare port and response traffic against queues.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic [3:0] rdy;
        logic       wen;
        logic       ren;
        logic [7:0] addr;
        logic [7:0] din;
    } gnt_t;

    typedef struct packed {
        logic [3:0]  vld;
        logic [7:0]  data;
        logic [31:0] t;
    } rsp_t;

`ifdef MEM_ARB_WR_PRIO_EN
    localparam logic [3:0] MIX_RDY = 4'b1000;
`else
    localparam logic [3:0] MIX_RDY = 4'b0001;
`endif
    localparam logic [31:0] A = 32'h04030201;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid, req_wr, req_lock;
    logic [31:0] req_addr, req_wdata;

    logic [3:0] rdy1, rv1, rdy2, rv2;
    logic [7:0] rd1, rd2, addr1, addr2, din1, din2;
    logic [7:0] dout1, dout2, r2a;
    logic       wen1, ren1, wen2, ren2;

    logic [7:0] ram1 [256];
    logic [7:0] ram2 [256];
    logic       ram_ok = 1'b0;

    int cyc  = 0;
    int nvec = 0;
    int nerr = 0;

    gnt_t gq[$];
    rsp_t rq1[$];
    rsp_t rq2[$];
    gnt_t ge;

    mem_port_arbiter #(
        .NUM_REQ(4), .WIDTH_DATA(8), .WIDTH_ADDR(8), .RD_LATENCY(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(rdy1),
        .req_wr(req_wr), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1),
        .mem_addr(addr1), .mem_din(din1),
        .mem_wen(wen1), .mem_ren(ren1), .mem_dout(dout1)
    );

    mem_port_arbiter #(
        .NUM_REQ(4), .WIDTH_DATA(8), .WIDTH_ADDR(8), .RD_LATENCY(2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(rdy2),
        .req_wr(req_wr), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rv2), .rsp_rdata(rd2),
        .mem_addr(addr2), .mem_din(din2),
        .mem_wen(wen2), .mem_ren(ren2), .mem_dout(dout2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Unwritten RAM locations read back as addr ^ 8'h5A.
    always @(posedge clk) begin
        if (!ram_ok) begin
            for (int i = 0; i < 256; i++) begin
                ram1[i] <= 8'(i) ^ 8'h5A;
                ram2[i] <= 8'(i) ^ 8'h5A;
            end
            ram_ok <= 1'b1;
        end else begin
            if (wen1) ram1[addr1] <= din1;
            if (ren1) dout1 <= ram1[addr1];
            if (wen2) ram2[addr2] <= din2;
            if (ren2) r2a <= ram2[addr2];
            dout2 <= r2a;
        end
    end

    task automatic chk_g(input string nm, input gnt_t act, input gnt_t exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL grant_%s cyc %0d: got rdy=%b wen=%b ren=%b addr=%h din=%h, want rdy=%b wen=%b ren=%b addr=%h din=%h",
                     nm, cyc, act.rdy, act.wen, act.ren, act.addr, act.din,
                     exp.rdy, exp.wen, exp.ren, exp.addr, exp.din);
        end
    endtask

    task automatic chk_r(input int id, input logic [3:0] v, input logic [7:0] d);
        rsp_t e;
        logic have;
        have = 1'b0;
        e    = '0;
        if (id == 1 && rq1.size() > 0) begin
            have = 1'b1;
            e    = rq1[0];
        end
        if (id == 2 && rq2.size() > 0) begin
            have = 1'b1;
            e    = rq2[0];
        end
        nvec++;
        if (v != 4'b0000) begin
            if (!have) begin
                nerr++;
                $display("FAIL rsp_unexpected dut%0d cyc %0d: got vld=%b data=%h, want none",
                         id, cyc, v, d);
            end else begin
                if (id == 1) void'(rq1.pop_front());
                else void'(rq2.pop_front());
                if (v !== e.vld || d !== e.data || e.t != cyc) begin
                    nerr++;
                    $display("FAIL rsp dut%0d cyc %0d: got vld=%b data=%h, want vld=%b data=%h at cyc %0d",
                             id, cyc, v, d, e.vld, e.data, e.t);
                end
            end
        end else begin
            if (d !== 8'h00) begin
                nerr++;
                $display("FAIL rsp_idle_data dut%0d cyc %0d: got %h, want 00", id, cyc, d);
            end
            if (have && e.t <= cyc) begin
                nerr++;
                $display("FAIL rsp_missing dut%0d cyc %0d: got vld=0000, want vld=%b data=%h",
                         id, cyc, e.vld, e.data);
                if (id == 1) void'(rq1.pop_front());
                else void'(rq2.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (gq.size() > 0) begin
            ge = gq.pop_front();
            chk_g("lat1", {rdy1, wen1, ren1, addr1, din1}, ge);
            chk_g("lat2", {rdy2, wen2, ren2, addr2, din2}, ge);
        end
    end

    always @(negedge clk) begin
        chk_r(1, rv1, rd1);
        chk_r(2, rv2, rd2);
    end

    // One cycle of stimulus; er/ed are the hand-derived grant and read data.
    // m selects which latency variants should still see the read response.
    task automatic apply(input logic r, input logic [3:0] v, input logic [3:0] wr,
                         input logic [3:0] lk, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] er,
                         input logic [7:0] ed, input logic [1:0] m);
        gnt_t e;
        @(posedge clk);
        #1;
        rst_n     = r;
        req_valid = v;
        req_wr    = wr;
        req_lock  = lk;
        req_addr  = a;
        req_wdata = d;
        e      = '0;
        e.rdy  = er;
        e.wen  = |(er & wr);
        e.ren  = |(er & ~wr);
        for (int i = 0; i < 4; i++) begin
            if (er[i]) begin
                e.addr = a[i*8 +: 8];
                e.din  = d[i*8 +: 8];
            end
        end
        gq.push_back(e);
        if (e.ren) begin
            if (m[0]) rq1.push_back({er, ed, 32'(cyc + 1)});
            if (m[1]) rq2.push_back({er, ed, 32'(cyc + 2)});
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        req_valid = '0;
        req_wr    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
        #2 rst_n = 1'b0;

        apply(0, 4'hF, 4'h0, 4'h0, A, 0, 4'b0000, 8'h00, 2'b11);
        apply(0, 4'hF, 4'h0, 4'h0, A, 0, 4'b0000, 8'h00, 2'b11);

        apply(1, 4'hF, 4'h0, 4'h0, A, 0, 4'b0001, 8'h5B, 2'b11);
        apply(1, 4'hF, 4'h0, 4'h0, A, 0, 4'b0010, 8'h58, 2'b11);
        apply(1, 4'hF, 4'h0, 4'h0, A, 0, 4'b0100, 8'h59, 2'b11);
        apply(1, 4'hF, 4'h0, 4'h0, A, 0, 4'b1000, 8'h5E, 2'b11);
        apply(1, 4'hF, 4'h0, 4'h0, A, 0, 4'b0001, 8'h5B, 2'b11);

        apply(1, 4'h0, 4'h0, 4'h0, A, 0, 4'b0000, 8'h00, 2'b11);
        apply(1, 4'h0, 4'h0, 4'h0, A, 0, 4'b0000, 8'h00, 2'b11);
        apply(1, 4'hF, 4'h0, 4'h0, A, 0, 4'b0010, 8'h58, 2'b11);

        apply(1, 4'b0100, 4'b0100, 4'h0, 32'h04100201, 32'h00A50000,
              4'b0100, 8'h00, 2'b11);
        apply(1, 4'b0001, 4'h0, 4'h0, 32'h04030210, 0, 4'b0001, 8'hA5, 2'b11);

        apply(1, 4'b1011, 4'h0, 4'b0010, A, 0, 4'b0010, 8'h58, 2'b11);
        apply(1, 4'b1011, 4'h0, 4'b0010, A, 0, 4'b0010, 8'h58, 2'b11);
        apply(1, 4'b1011, 4'h0, 4'b0010, A, 0, 4'b0010, 8'h58, 2'b11);
        apply(1, 4'b1011, 4'h0, 4'b0000, A, 0, 4'b1000, 8'h5E, 2'b11);

        apply(1, 4'b0010, 4'h0, 4'b0010, A, 0, 4'b0010, 8'h58, 2'b11);
        apply(1, 4'b1001, 4'h0, 4'b0010, A, 0, 4'b0000, 8'h00, 2'b11);
        apply(1, 4'b1001, 4'h0, 4'b0000, A, 0, 4'b1000, 8'h5E, 2'b11);

        apply(1, 4'b1001, 4'b1000, 4'h0, 32'h40030201, 32'h3C000000,
              MIX_RDY, 8'h5B, 2'b11);
        apply(1, 4'b1001, 4'b1000, 4'h0, 32'h40030201, 32'h3C000000,
              4'b1000, 8'h00, 2'b11);
        apply(1, 4'b1000, 4'h0, 4'h0, 32'h40030201, 0, 4'b1000, 8'h3C, 2'b11);

        apply(1, 4'hF, 4'h0, 4'h0, A, 0, 4'b0001, 8'h5B, 2'b01);
        apply(1, 4'hF, 4'h0, 4'h0, A, 0, 4'b0010, 8'h58, 2'b00);
        apply(0, 4'hF, 4'h0, 4'h0, A, 0, 4'b0000, 8'h00, 2'b11);
        apply(0, 4'hF, 4'h0, 4'h0, A, 0, 4'b0000, 8'h00, 2'b11);
        apply(1, 4'hF, 4'h0, 4'h0, A, 0, 4'b0001, 8'h5B, 2'b11);
        apply(1, 4'hF, 4'h0, 4'h0, A, 0, 4'b0010, 8'h58, 2'b11);

        apply(1, 4'h0, 4'h0, 4'h0, A, 0, 4'b0000, 8'h00, 2'b11);
        apply(1, 4'h0, 4'h0, 4'h0, A, 0, 4'b0000, 8'h00, 2'b11);
        apply(1, 4'h0, 4'h0, 4'h0, A, 0, 4'b0000, 8'h00, 2'b11);
        repeat (3) @(posedge clk);
        #1;

        nvec++;
        if (gq.size() + rq1.size() + rq2.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d/%0d/%0d entries left, want 0/0/0",
                     gq.size(), rq1.size(), rq2.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the requester count (2..8).
REQ-002 The block SHALL have parameter WIDTH_DATA, default 8, giving the memory data width.
REQ-003 The block SHALL have parameter WIDTH_ADDR, default 8, giving the memory address width.
REQ-004 The block SHALL have parameter RD_LATENCY, default 1, giving the memory read latency (1 = unregistered dout, 2 = registered dout).
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port req_valid, input, NUM_REQ bits: request valid, one bit per requester.
REQ-008 The block SHALL have port req_ready, output, NUM_REQ bits: grant/accept, one-hot or zero.
REQ-009 The block SHALL have port req_wr, input, NUM_REQ bits: 1 = write, 0 = read.
REQ-010 The block SHALL have port req_lock, input, NUM_REQ bits: burst lock request.
REQ-011 The block SHALL have port req_addr, input, NUM_REQ*WIDTH_ADDR bits: packed addresses, requester i at slice i.
REQ-012 The block SHALL have port req_wdata, input, NUM_REQ*WIDTH_DATA bits: packed write data.
REQ-013 The block SHALL have port rsp_valid, output, NUM_REQ bits: read data valid for requester i.
REQ-014 The block SHALL have port rsp_rdata, output, WIDTH_DATA bits: shared read data.
REQ-015 The block SHALL have ports mem_addr (WIDTH_ADDR), mem_din (WIDTH_DATA), mem_wen (1) and mem_ren (1), all outputs, which drive one RAM port.
REQ-016 The block SHALL have port mem_dout, input, WIDTH_DATA bits: RAM port read data.

Function
REQ-017 Each cycle, the block SHALL grant at most one requester with req_valid=1; the grant is combinational.
REQ-018 Arbitration SHALL be round-robin: the search starts at rr_ptr and wraps from NUM_REQ-1 to 0.
REQ-019 On each handshake (req_valid[i] & req_ready[i]), rr_ptr SHALL become (i+1) mod NUM_REQ; it SHALL hold otherwise.
REQ-020 Lock state machine: there SHALL be two states, IDLE and LOCKED, plus a lock_id register.
REQ-021 IDLE->LOCKED SHALL occur on a handshake of requester i with req_lock[i]=1, which sets lock_id=i.
REQ-022 In LOCKED, only lock_id SHALL be eligible; other requesters receive req_ready=0.
REQ-023 LOCKED->IDLE SHALL occur on the first cycle where req_lock[lock_id]=0, and arbitration is normal in that same cycle.
REQ-024 In LOCKED with req_valid[lock_id]=0, no grant SHALL be issued (the port idles).
REQ-025 The granted request SHALL drive mem_addr, mem_din, mem_wen=req_wr and mem_ren=~req_wr in the same cycle.
REQ-026 With no grant, mem_wen and mem_ren SHALL be 0; mem_addr and mem_din are don't-care but SHALL be 0.
REQ-027 A read accepted in cycle T SHALL assert rsp_valid[i] for exactly one cycle at T+RD_LATENCY, with rsp_rdata = mem_dout in that cycle.
REQ-028 A RD_LATENCY-deep tag pipeline (valid plus id) SHALL track in-flight reads; back-to-back reads SHALL be supported every cycle.
REQ-029 When no rsp_valid bit is set, rsp_rdata SHALL be 0.
REQ-030 Writes SHALL produce no response.
REQ-031 Throughput SHALL be one access per cycle, with no bubbles between grants.

Reset
REQ-032 While rst_n=0, the block SHALL hold rr_ptr=0, state=IDLE, lock_id=0, the tag pipeline cleared, req_ready=0, rsp_valid=0, rsp_rdata=0, mem_wen=0, mem_ren=0, mem_addr=0 and mem_din=0.
REQ-033 Reset asserted mid-operation SHALL discard in-flight read tags; no rsp_valid SHALL appear after release for reads issued before reset.
REQ-034 Reset deassertion is synchronised externally; the first grant MAY occur on the first clock edge after release.

Configuration
REQ-035 Macro MEM_ARB_WR_PRIO_EN SHALL control write priority.
REQ-036 With MEM_ARB_WR_PRIO_EN defined, when any eligible requester has req_valid=1 and req_wr=1, only writers SHALL be eligible, selected round-robin among them; LOCKED state still overrides.
REQ-037 Without MEM_ARB_WR_PRIO_EN defined, reads and writes SHALL have equal priority under REQ-018.

Verification
REQ-038 After reset, req_valid=4'b1111, all reads, lock=0, RD_LATENCY=1 -> grants 0,1,2,3,0 on consecutive cycles, and rsp_valid one-hot one cycle later with matching id.
REQ-039 Requester 2 writes addr 8'h10 data 8'hA5, then requester 0 reads addr 8'h10 -> rsp_valid=4'b0001 and rsp_rdata=8'hA5 at read cycle+RD_LATENCY (check with RD_LATENCY=1 and 2).
REQ-040 Requester 1 holds lock for 3 handshakes while 0 and 3 request -> only 1 is granted for 3 cycles, then 3 is granted in the cycle after lock drops.
REQ-041 Reads issued on consecutive cycles with rst_n pulsed low at cycle 2, RD_LATENCY=2 -> no rsp_valid after release, and rr_ptr restarts at 0.
REQ-042 With MEM_ARB_WR_PRIO_EN defined: requester 0 reads while requester 3 writes, rr_ptr=0 -> requester 3 is granted first; without the macro, requester 0 is granted first.
REQ-043 req_valid=0 for all requesters -> req_ready=0, mem_wen=0, mem_ren=0, and rr_ptr unchanged.
